// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO word offsets,
// STATUS bit layout and the STATUS word packer.
package dmem_pkg;

    localparam logic [31:0] MMIO_BASE_DEF = 32'h8000_0000;

    // Word offsets within the MMIO window, compared against daddr[3:2]
    localparam logic [1:0] TXDATA_OFF = 2'd0;
    localparam logic [1:0] STATUS_OFF = 2'd1;
    localparam logic [1:0] CYCLE_OFF  = 2'd2;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    function automatic logic [31:0] status_word(input logic full, input logic empty,
                                                input logic ovf, input logic [7:0] cnt);
        logic [31:0] w;
        w = '0;
        w[ST_FULL]                 = full;
        w[ST_EMPTY]                = empty;
        w[ST_OVF]                  = ovf;
        w[ST_CNT_LSB +: 8]         = cnt;
        return w;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core data-memory bus plus the TX byte stream, as seen by the responder.
interface dmem_responder_if;
    logic [31:0] daddr;
    logic [31:0] drdata;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport slave  (input  daddr, dwdata, dwe, tx_ready,
                    output drdata, tx_data, tx_valid);
    modport master (output daddr, dwdata, dwe, tx_ready,
                    input  drdata, tx_data, tx_valid);
endinterface

// File: rtl/dmem_responder_sync_fifo.sv
// Synchronous FIFO; a push is accepted when full only if a pop frees a slot
// in the same cycle. The head reads as zero while empty.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PW:0]      count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign count_o = cnt_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_d  = wr_q + PW'(push_ok);
        rd_d  = rd_q + PW'(pop_ok);
        cnt_d = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: combinational-read RAM with byte-lane writes, plus an
// MMIO window holding the TX FIFO, its STATUS word and a free-running cycle counter.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          MEM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram_q [MEM_WORDS];
    logic [31:0]   cyc_q, cyc_d;
    logic          ovf_q, ovf_d;
    logic          mmio_sel, wr_en;
    logic [AW-1:0] word_idx;
    logic [1:0]    off;
    logic          push, pop, ovf_clr, cyc_we;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic [7:0]    cnt8;
    logic          unused_bits;

    assign mmio_sel = (bus.daddr[31] == MMIO_BASE[31]);
    assign word_idx = bus.daddr[AW+1:2];
    assign off      = bus.daddr[3:2];
    assign wr_en    = !reset;
    assign unused_bits = ^{bus.daddr[30:AW+2], bus.daddr[1:0], MMIO_BASE[30:0]};

    assign push    = wr_en && mmio_sel && off == TXDATA_OFF && bus.dwe[0];
    assign pop     = bus.tx_valid && bus.tx_ready;
    assign ovf_clr = wr_en && mmio_sel && off == STATUS_OFF && bus.dwe[0] && bus.dwdata[ST_OVF];
    assign cyc_we  = wr_en && mmio_sel && off == CYCLE_OFF && (|bus.dwe);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_txq (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .din_i   (bus.dwdata[7:0]),
        .pop_i   (pop),
        .dout_o  (bus.tx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign bus.tx_valid = !fifo_empty;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && !mmio_sel && bus.dwe[i])
                ram_q[word_idx][8*i +: 8] <= bus.dwdata[8*i +: 8];
        end
    end

    // A CYCLE write replaces the increment; lanes not written hold their value
    always_comb begin
        cyc_d = cyc_q + 32'd1;
        if (cyc_we) begin
            cyc_d = cyc_q;
            for (int i = 0; i < 4; i++)
                if (bus.dwe[i]) cyc_d[8*i +: 8] = bus.dwdata[8*i +: 8];
        end
        ovf_d = ovf_q;
        if (push && fifo_full && !pop) ovf_d = 1'b1;
        if (ovf_clr)                   ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cyc_q <= cyc_d;
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        cnt8 = '0;
        cnt8[CW-1:0] = fifo_cnt;
        bus.drdata = '0;
        if (!mmio_sel) begin
            bus.drdata = ram_q[word_idx];
        end else begin
            case (off)
                STATUS_OFF: bus.drdata = status_word(fifo_full, fifo_empty, ovf_q, cnt8);
                CYCLE_OFF:  bus.drdata = cyc_q;
                default:    bus.drdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder against a queue/array reference model,
// with directed scenarios for lanes, FIFO order, overflow, CYCLE wrap and reset.
module tb_dmem_responder;
    localparam int MEM_WORDS = 1024;
    localparam int DEPTH     = 8;
    localparam logic [31:0] MB = 32'h8000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_responder_if bus();

    dmem_responder #(.MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(DEPTH), .MMIO_BASE(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] m_ram [MEM_WORDS];
    bit          m_known [MEM_WORDS];
    byte unsigned m_q [$];
    bit          m_ovf;
    logic [31:0] m_cyc;
    bit          m_init = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % MEM_WORDS);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int n;
        n = m_q.size();
        if (!a[31]) return m_ram[widx(a)];
        case (int'((a >> 2) & 32'd3))
            1:       return (32'(n) << 8) | (32'(m_ovf) << 2) | (32'(n == 0) << 1) | 32'(n == DEPTH);
            2:       return m_cyc;
            default: return 32'd0;
        endcase
    endfunction

    // One bus cycle: drive, compare outputs against the model, clock, update the model.
    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                        input logic rdy, input logic rst,
                        output logic [31:0] rd, output logic txv, output logic [7:0] txd);
        bit pop, mmio;
        int off, n0, ix;
        logic [31:0] nc;
        bus.daddr = a; bus.dwdata = wd; bus.dwe = we; bus.tx_ready = rdy; reset = rst;
        @(negedge clk);
        rd = bus.drdata; txv = bus.tx_valid; txd = bus.tx_data;
        if (m_init) begin
            if (a[31] || m_known[widx(a)]) chk("drdata", rd, m_read(a));
            chk("tx_valid", 32'(txv), 32'(m_q.size() != 0));
            chk("tx_data", 32'(txd), m_q.size() != 0 ? 32'(m_q[0]) : 32'd0);
        end
        @(posedge clk); #1;
        if (rst) begin
            m_q.delete(); m_ovf = 0; m_cyc = 0; m_init = 1;
        end else begin
            n0   = m_q.size();
            pop  = (n0 != 0) && rdy;
            mmio = a[31];
            off  = int'((a >> 2) & 32'd3);
            ix   = widx(a);
            if (!mmio) begin
                for (int l = 0; l < 4; l++) if (we[l]) m_ram[ix][8*l +: 8] = wd[8*l +: 8];
                if (we == 4'hF) m_known[ix] = 1;
            end
            nc = m_cyc + 1;
            if (mmio && off == 2 && we != 0) begin
                nc = m_cyc;
                for (int l = 0; l < 4; l++) if (we[l]) nc[8*l +: 8] = wd[8*l +: 8];
            end
            m_cyc = nc;
            if (pop) void'(m_q.pop_front());
            if (mmio && off == 0 && we[0]) begin
                if (n0 == DEPTH && !pop) m_ovf = 1;
                else m_q.push_back(wd[7:0]);
            end
            if (mmio && off == 1 && we[0] && wd[2]) m_ovf = 0;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 1) == 0) begin
            a[31]   = 1'b0;
            a[11:2] = 10'($urandom_range(0, 15));
        end else begin
            a[31] = 1'b1;
        end
        return a;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, a, wd;
        logic        v;
        logic [7:0]  d;
        logic [3:0]  we;
        logic [7:0]  last;
        for (int i = 0; i < MEM_WORDS; i++) m_known[i] = 0;
        reset = 1; bus.daddr = 0; bus.dwdata = 0; bus.dwe = 0; bus.tx_ready = 0;
        @(posedge clk); #1;
        step(32'h0, 32'h0, 4'h0, 1'b0, 1'b1, rd, v, d);
        step(MB + 4, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, rd, v, d);
        chk("rst_status", rd, 32'h0000_0002);
        chk("rst_txdata", 32'(d), 32'h0);

        for (int i = 0; i < 5; i++) step(MB + 8, 32'h0, 4'h0, 1'b0, 1'b0, rd, v, d);
        step(MB + 8, 32'h0, 4'h0, 1'b0, 1'b0, rd, v, d);
        chk("cycle5", rd, 32'd5);

        for (int i = 0; i < 16; i++) step(32'(i * 4), $urandom, 4'hF, 1'b0, 1'b0, rd, v, d);

        step(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, rd, v, d);
        step(32'h10, 32'h0000_00AA, 4'h1, 1'b0, 1'b0, rd, v, d);
        step(32'h10, 32'h0, 4'h0, 1'b0, 1'b0, rd, v, d);
        chk("lane_rd10", rd, 32'hDEAD_BEAA);
        step(32'h13, 32'h0, 4'h0, 1'b0, 1'b0, rd, v, d);
        chk("lane_rd13", rd, 32'hDEAD_BEAA);

        for (int i = 0; i < 3; i++) step(MB, 32'h41 + 32'(i), 4'h1, 1'b0, 1'b0, rd, v, d);
        step(MB + 4, 32'h0, 4'h0, 1'b0, 1'b0, rd, v, d);
        chk("fifo3_status", rd, 32'h0000_0300);
        for (int i = 0; i < 3; i++) begin
            step(MB + 4, 32'h0, 4'h0, 1'b1, 1'b0, rd, v, d);
            chk("drain_byte", 32'(d), 32'h41 + 32'(i));
        end
        step(MB + 4, 32'h0, 4'h0, 1'b1, 1'b0, rd, v, d);
        chk("drained_valid", 32'(v), 32'h0);
        chk("drained_empty", 32'(rd[1]), 32'h1);

        for (int i = 0; i < 9; i++) step(MB, 32'h50 + 32'(i), 4'h1, 1'b0, 1'b0, rd, v, d);
        step(MB + 4, 32'h0, 4'h0, 1'b0, 1'b0, rd, v, d);
        chk("ovf_status", rd, 32'h0000_0805);
        step(MB + 4, 32'h4, 4'h1, 1'b0, 1'b0, rd, v, d);
        step(MB + 4, 32'h0, 4'h0, 1'b0, 1'b0, rd, v, d);
        chk("ovf_cleared", rd, 32'h0000_0801);

        step(MB, 32'h99, 4'h1, 1'b1, 1'b0, rd, v, d);
        step(MB + 4, 32'h0, 4'h0, 1'b0, 1'b0, rd, v, d);
        chk("full_pushpop", rd, 32'h0000_0801);
        last = 8'h0;
        for (int i = 0; i < 8; i++) begin
            step(MB + 12, 32'h0, 4'h0, 1'b1, 1'b0, rd, v, d);
            if (i == 0) chk("full_first", 32'(d), 32'h51);
            last = d;
        end
        chk("full_last", 32'(last), 32'h99);

        step(MB + 8, 32'hFFFF_FFFE, 4'hF, 1'b0, 1'b0, rd, v, d);
        step(MB + 8, 32'h0, 4'h0, 1'b0, 1'b0, rd, v, d);
        chk("cyc_load", rd, 32'hFFFF_FFFE);
        step(MB + 8, 32'h0, 4'h0, 1'b0, 1'b0, rd, v, d);
        chk("cyc_max", rd, 32'hFFFF_FFFF);
        step(MB + 8, 32'h0, 4'h0, 1'b0, 1'b0, rd, v, d);
        chk("cyc_wrap", rd, 32'h0);

        for (int i = 0; i < 3; i++) step(MB, 32'h61 + 32'(i), 4'h1, 1'b0, 1'b0, rd, v, d);
        step(32'h10, 32'h1234_5678, 4'hF, 1'b0, 1'b1, rd, v, d);
        step(MB + 8, 32'h0, 4'h0, 1'b0, 1'b0, rd, v, d);
        chk("mid_rst_valid", 32'(v), 32'h0);
        chk("mid_rst_cycle", rd, 32'h0);
        step(MB + 4, 32'h0, 4'h0, 1'b0, 1'b0, rd, v, d);
        chk("mid_rst_status", rd, 32'h0000_0002);
        step(32'h10, 32'h0, 4'h0, 1'b0, 1'b0, rd, v, d);
        chk("mid_rst_ram", rd, 32'hDEAD_BEAA);

        for (int i = 0; i < 2000; i++) begin
            a  = rand_addr();
            wd = $urandom;
            we = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            if (a[31] && a[3:2] == 2'd1 && $urandom_range(0, 3) != 0) wd[2] = 1'b0;
            if (a[31] && a[3:2] == 2'd2 && $urandom_range(0, 3) != 0) we = 4'h0;
            step(a, wd, we, 1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 299) == 0), rd, v, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
